remote_comm: RTL and testbench

//  Host/remote end of the quadcopter BLE command link. Serializes a command

---
 rtl/remote_comm.sv | 231 +++++++++++++++++++++++
 tb/tb_remote_comm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// Host-side BLE command link: sends a 3-byte 8N1 command frame on TX and receives a 1-byte response on RX.
// Optional response watchdog enabled by defining RESP_TIMEOUT_EN.
module remote_comm #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        timeout
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 2 - 1);

    generate
        if (BAUD_DIV < 4) begin : g_bad_baud
            $error("remote_comm: BAUD_DIV must be at least 4");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("remote_comm: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, TX_CMD, TX_DHI, TX_DLO, WAIT_RESP} state_t;

    state_t          state_q, state_d;
    logic [23:0]     frame_q, frame_d;
    logic            cmd_sent_q, cmd_sent_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      resp_q, resp_d;
    logic            resp_rdy_q, resp_rdy_d;
    logic            accept;

    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [BW-1:0]   tx_baud_q, tx_baud_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic            tx_active_q, tx_active_d;
    logic            tx_done, tx_load;
    logic [7:0]      tx_byte;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic            rx_active_q, rx_active_d;
    logic [BW-1:0]   rx_baud_q, rx_baud_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid;

`ifdef RESP_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0]   wd_q, wd_d;
`endif

    assign tx_done = tx_active_q && (tx_bit_q == 4'd9) && (tx_baud_q == BAUD_LAST);

    // Command FSM: each TX state hands the next byte to the shifter in the done cycle, so bytes abut.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tx_load    = 1'b0;
        tx_byte    = frame_q[23:16];
        cmd_sent_d = 1'b0;
        timeout_d  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: if (snd_cmd) begin
                accept  = 1'b1;
                frame_d = {cmd, data};
                tx_load = 1'b1;
                tx_byte = cmd;
                state_d = TX_CMD;
            end
            TX_CMD: if (tx_done) begin
                tx_load = 1'b1;
                tx_byte = frame_q[15:8];
                state_d = TX_DHI;
            end
            TX_DHI: if (tx_done) begin
                tx_load = 1'b1;
                tx_byte = frame_q[7:0];
                state_d = TX_DLO;
            end
            TX_DLO: if (tx_done) begin
                cmd_sent_d = 1'b1;
                state_d    = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (rx_valid) begin
                    state_d = IDLE;
                end
`ifdef RESP_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RESP_TIMEOUT_EN
    assign wd_d = (state_q == WAIT_RESP) ? wd_q + 1'b1 : '0;
`endif

    always_comb begin
        tx_shift_d  = tx_shift_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_active_d = tx_active_q;
        if (tx_load) begin
            tx_shift_d  = {1'b1, tx_byte, 1'b0};
            tx_baud_d   = '0;
            tx_bit_d    = 4'd0;
            tx_active_d = 1'b1;
        end else if (tx_active_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_d  = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_bit_d    = 4'd0;
                    tx_active_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_d = tx_baud_q + 1'b1;
            end
        end
    end

    // Receiver: bit 0 is the start bit (re-checked mid-bit), 1..8 data, 9 stop.
    always_comb begin
        rx_active_d = rx_active_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_valid    = 1'b0;
        if (!rx_active_q) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_active_d = 1'b1;
                rx_baud_d   = '0;
                rx_bit_d    = 4'd0;
            end
        end else begin
            if (rx_baud_q == BAUD_LAST) begin
                rx_baud_d = '0;
                rx_bit_d  = rx_bit_q + 4'd1;
            end else begin
                rx_baud_d = rx_baud_q + 1'b1;
            end
            if (rx_baud_q == BAUD_MID) begin
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_active_d = 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_active_d = 1'b0;
                    rx_valid    = rx_s2_q;
                end else begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                end
            end
        end
    end

    assign resp_d     = rx_valid ? rx_shift_q : resp_q;
    assign resp_rdy_d = rx_valid ? 1'b1 : ((clr_resp_rdy || accept) ? 1'b0 : resp_rdy_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            cmd_sent_q  <= 1'b0;
            timeout_q   <= 1'b0;
            resp_q      <= 8'h00;
            resp_rdy_q  <= 1'b0;
            tx_shift_q  <= '1;
            tx_baud_q   <= '0;
            tx_bit_q    <= 4'd0;
            tx_active_q <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_active_q <= 1'b0;
            rx_baud_q   <= '0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'h00;
`ifdef RESP_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cmd_sent_q  <= cmd_sent_d;
            timeout_q   <= timeout_d;
            resp_q      <= resp_d;
            resp_rdy_q  <= resp_rdy_d;
            tx_shift_q  <= tx_shift_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_active_q <= tx_active_d;
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_active_q <= rx_active_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
`ifdef RESP_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign TX       = tx_shift_q[0];
    assign busy     = (state_q != IDLE);
    assign cmd_sent = cmd_sent_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: expected TX bytes and responses are queued at stimulus time and
// checked by independent TX-decoder and response monitors.
module tb_remote_comm;
    localparam int B = 16;
    localparam int T = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        clr_resp_rdy = 1'b0;
    logic        RX = 1'b1;
    logic        TX, busy, cmd_sent, resp_rdy, timeout;
    logic [7:0]  resp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cs_cyc = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] resp_exp[$];

    remote_comm #(.BAUD_DIV(B), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
        .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .busy(busy),
        .cmd_sent(cmd_sent), .resp(resp), .resp_rdy(resp_rdy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // TX decoder: samples mid-bit from the first low cycle; a reset drops any partial frame.
    initial begin
        int mcnt;
        int k;
        bit mact;
        logic [7:0] mbyte;
        logic [7:0] e;
        mcnt = 0;
        mact = 0;
        mbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                mact = 0;
            end else if (!mact) begin
                if (TX === 1'b0) begin
                    mact = 1;
                    mcnt = 0;
                end
            end else begin
                mcnt = mcnt + 1;
                if (mcnt % B == B / 2) begin
                    k = mcnt / B;
                    if (k == 0) begin
                        if (TX !== 1'b0) mact = 0;
                    end else if (k <= 8) begin
                        mbyte[k-1] = TX;
                    end else begin
                        mact = 0;
                        chk("tx_stop", 32'(TX), 32'd1);
                        if (tx_exp.size() == 0) begin
                            total = total + 1;
                            bad = bad + 1;
                            $display("FAIL tx_unexpected: got=%02h expected=none", mbyte);
                        end else begin
                            e = tx_exp.pop_front();
                            $display("tx byte got=%02h expected=%02h", mbyte, e);
                            chk("tx_byte", 32'(mbyte), 32'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy === 1'b1 && prev !== 1'b1) begin
                if (resp_exp.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL resp_unexpected: got=%02h expected=none", resp);
                end else begin
                    e = resp_exp.pop_front();
                    $display("resp byte got=%02h expected=%02h", resp, e);
                    chk("resp_byte", 32'(resp), 32'(e));
                end
            end
            prev = resp_rdy;
        end
    end

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
        @(negedge clk);
        cmd = c;
        data = d;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        $display("cmd issued cmd=%02h data=%04h", c, d);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Counts edges after the accept edge until cmd_sent; optionally fires an ignored snd_cmd at edge 100.
    task automatic wait_sent(input bit inject);
        int n;
        bit found;
        bit busy_ok;
        n = 0;
        found = 0;
        busy_ok = 1;
        for (int i = 1; i <= 600 && !found; i++) begin
            @(posedge clk);
            #1;
            if (inject) begin
                snd_cmd = (i == 100);
                if (i == 100) begin
                    cmd = 8'hFF;
                    data = 16'hFFFF;
                end
            end
            if (cmd_sent === 1'b1) begin
                found = 1;
                n = i;
                cs_cyc = cyc;
            end else if (busy !== 1'b1) begin
                busy_ok = 0;
            end
        end
        snd_cmd = 1'b0;
        chk("busy_during_frame", 32'(busy_ok), 32'd1);
        chk("cmd_sent_latency", 32'(n), 32'd480);
        @(posedge clk);
        #1;
        chk("cmd_sent_one_cycle", 32'(cmd_sent), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        $display("rx frame sent byte=%02h stop=%0d", b, stop_bit);
    endtask

    initial begin
        int tcyc;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_sent", 32'(cmd_sent), 32'd0);
        chk("rst_resp", 32'(resp), 32'h00);
        chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Frame 02/1234 with an ignored snd_cmd (cmd FF) mid-frame
        tx_exp.push_back(8'h02);
        tx_exp.push_back(8'h12);
        tx_exp.push_back(8'h34);
        send_cmd(8'h02, 16'h1234);
        wait_sent(1'b1);

        // Valid response A5, then clear
        resp_exp.push_back(8'hA5);
        send_rx(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("resp_value", 32'(resp), 32'hA5);
        chk("resp_rdy_set", 32'(resp_rdy), 32'd1);
        chk("busy_after_resp", 32'(busy), 32'd0);
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        chk("resp_rdy_cleared", 32'(resp_rdy), 32'd0);

        // Framing error and start-bit glitch while waiting for a response
        tx_exp.push_back(8'h02);
        tx_exp.push_back(8'h12);
        tx_exp.push_back(8'h34);
        send_cmd(8'h02, 16'h1234);
        wait_sent(1'b0);
        send_rx(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        chk("framing_err_rdy", 32'(resp_rdy), 32'd0);
        chk("framing_err_busy", 32'(busy), 32'd1);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_rdy", 32'(resp_rdy), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd1);
        chk("resp_kept", 32'(resp), 32'hA5);

        // Response watchdog
        seen = 0;
        tcyc = 0;
        while (cyc < cs_cyc + 1100 && !seen) begin
            @(posedge clk);
            #1;
            if (timeout === 1'b1) begin
                seen = 1;
                tcyc = cyc;
            end
        end
`ifdef RESP_TIMEOUT_EN
        chk("timeout_latency", 32'(tcyc - cs_cyc), 32'd1000);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout_one_cycle", 32'(timeout), 32'd0);
        chk("resp_after_timeout", 32'(resp), 32'hA5);
`else
        chk("no_timeout", 32'(seen), 32'd0);
        chk("busy_waits", 32'(busy), 32'd1);
`endif
        $display("watchdog phase done seen=%0d", seen);

        // Reset during the second byte, then a full new frame
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        tx_exp.push_back(8'h02);
        send_cmd(8'h02, 16'h1234);
        repeat (164) @(posedge clk);
        #1;
        chk("tx_low_before_rst", 32'(TX), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(TX), 32'd1);
        chk("rst_async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        tx_exp.push_back(8'h3C);
        tx_exp.push_back(8'hBE);
        tx_exp.push_back(8'hEF);
        send_cmd(8'h3C, 16'hBEEF);
        wait_sent(1'b0);
        repeat (5) @(negedge clk);
        chk("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
        chk("resp_queue_drained", 32'(resp_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
